decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised RV32I/RV64I instruction decode stage sitting between fetch and register read.
- Splits fields, generates the XLEN-wide sign-extended immediate, classifies format and flags illegal encodings.
- Valid/ready handshake on both sides; a 2-entry skid buffer gives full throughput under backpressure.
- Carries the PC alongside each decoded instruction.

Parameters:
- XLEN, 32, datapath width for oImm/iPc/oPc; legal values 32 or 64.
- RV64_OPS, 0, when 1 (requires XLEN=64), opcodes OP-IMM-32 (0011011) and OP-32 (0111011) are legal.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iFlush  in  1  synchronous kill of all buffered entries.
- iValid  in  1  upstream instruction valid.
- oReady  out  1  stage can accept; registered.
- iInstr  in  32  instruction word.
- iPc  in  XLEN  instruction PC.
- oValid  out  1  decoded bundle valid.
- iReady  in  1  downstream accepts.
- oOpcode  out  7  instr[6:0].
- oRd  out  5  instr[11:7].
- oFunct3  out  3  instr[14:12].
- oRs1  out  5  instr[19:15].
- oRs2  out  5  instr[24:20].
- oFunct7  out  7  instr[31:25].
- oImm  out  XLEN  sign-extended immediate.
- oFmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- oPc  out  XLEN  PC of the decoded instruction.
- oIllegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset values: oValid=0, oReady=1, all data outputs 0, oFmt=NONE, oIllegal=0, both buffer entries invalid.
- Latency: 1 cycle from accepted input (iValid&&oReady at edge) to oValid.
- Transfer out occurs on oValid&&iReady at the clock edge.
- Buffer states: EMPTY, ONE (output register valid), FULL (output + skid valid).
- EMPTY: accept moves to ONE.
- ONE: accept without drain moves to FULL; drain without accept moves to EMPTY; accept with drain stays ONE with new data.
- FULL: drain moves skid to the output register and goes to ONE. oReady=0 in FULL, so no accept is possible.
- oReady = !FULL, driven from a register (no combinational path from iReady).
- Order preserved. While oValid&&!iReady, all outputs hold stable.
- Decode happens before the register; outputs are registered. Field outputs are raw bit slices regardless of format.
- Immediate, sign-extended from instr[31] to XLEN:
  - I: [31:20].
  - S: [31:25],[11:7].
  - B: [31],[7],[30:25],[11:8],0.
  - U: [31:12],12'b0, upper XLEN-32 bits = instr[31].
  - J: [31],[19:12],[20],[30:21],0.
  - R/NONE: 0.
- Format map:
  - R: 0110011; 0111011 if RV64_OPS.
  - I: 0010011, 0000011, 1100111, 0001111, 1110011; 0011011 if RV64_OPS.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Illegal: instr[1:0]!=2'b11 or opcode not in the map. Then oFmt=NONE, oImm=0, oIllegal=1; the entry is still passed through with oValid=1.
- iFlush: at the edge, both entries are invalidated, state goes EMPTY, oValid=0. An input presented in the flush cycle is dropped. Flush wins over a simultaneous accept or drain.
- Reset mid-operation: immediate return to reset values regardless of handshake state.

Optional Feature:
- Macro DECODE_STAGE_PERF_EN.
- Defined: adds output oRetCnt[31:0], counting instructions transferred out (oValid&&iReady), and oIllCnt[15:0], counting transferred illegal entries.
  - Both wrap modulo 2^n and reset to 0.
  - Flushed entries are not counted.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- decode_pkg: opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM, OPC_OP_IMM_32, OPC_OP_32) and the FMT_* encodings.
- Sub-module decode_imm_gen, combinational: instr in; imm, fmt, illegal out; parametrised by XLEN and RV64_OPS.
- decode_stage holds the skid buffer and handshake.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), XLEN=32, iReady=1 → next cycle oValid=1, oImm=0xFFFFFFFF, oFmt=1, oRd=1, oIllegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) → oImm=0xFFFFFFFC, oFmt=3; LUI x1,0x80000 (0x800000B7) with XLEN=64 → oImm=0xFFFFFFFF80000000, oFmt=4.
- Push PCs 0x0,0x4,0x8 back-to-back with iReady=0 → oReady=0 after two accepts, third held upstream; raising iReady drains 0x0,0x4,0x8 in order with no gap or duplicate.
- 0x00000000 and opcode 0111011 with RV64_OPS=0 → oIllegal=1, oFmt=7, oImm=0, oValid=1.
- FULL state plus iFlush together with iValid=1 → next cycle oValid=0, oReady=1, the new instruction is dropped.
- iRst pulsed asynchronously while FULL → outputs go to reset values before the next edge; with DECODE_STAGE_PERF_EN, oRetCnt=0.

Source files
------------

// File: rtl/decode_pkg.sv
// RV32I/RV64I opcode map, decoded-format encodings and skid-buffer states.
// Pure definitions: no logic, no latency, no flow control.
package decode_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } bufState_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational format classifier and XLEN-wide sign-extended immediate generator.
// Zero latency; no flow control. Unmapped opcodes give FMT_NONE, imm 0, illegal.
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input  logic [31:0]     iInstr,
  output logic [XLEN-1:0] oImm,
  output logic [2:0]      oFmt,
  output logic            oIllegal
);

  logic [2:0]        fmt;
  logic signed [31:0] imm32;

  always_comb begin
    fmt = FMT_NONE;
    case (iInstr[6:0])
      OPC_OP:                                             fmt = FMT_R;
      OPC_OP_32:                                          fmt = RV64_OPS ? FMT_R : FMT_NONE;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
      OPC_OP_IMM_32:                                      fmt = RV64_OPS ? FMT_I : FMT_NONE;
      OPC_STORE:                                          fmt = FMT_S;
      OPC_BRANCH:                                         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                                 fmt = FMT_U;
      OPC_JAL:                                            fmt = FMT_J;
      default:                                            fmt = FMT_NONE;
    endcase
    if (iInstr[1:0] != 2'b11) fmt = FMT_NONE;

    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{iInstr[31]}}, iInstr[31:20]};
      FMT_S:   imm32 = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
      FMT_B:   imm32 = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
      FMT_U:   imm32 = {iInstr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast replicates instr[31] into the upper XLEN-32 bits.
  assign oImm     = XLEN'(imm32);
  assign oFmt     = fmt;
  assign oIllegal = (fmt == FMT_NONE);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer; 1-cycle latency, full throughput.
// oReady is registered (low only when FULL); iFlush kills both entries. DECODE_STAGE_PERF_EN adds counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iFlush,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInstr,
  input  logic [XLEN-1:0] iPc,
  output logic            oValid,
  input  logic            iReady,
  output logic [6:0]      oOpcode,
  output logic [4:0]      oRd,
  output logic [2:0]      oFunct3,
  output logic [4:0]      oRs1,
  output logic [4:0]      oRs2,
  output logic [6:0]      oFunct7,
  output logic [XLEN-1:0] oImm,
  output logic [2:0]      oFmt,
  output logic [XLEN-1:0] oPc,
  output logic            oIllegal
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]     oRetCnt,
  output logic [15:0]     oIllCnt
`endif
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  bundle_t   decIn, outQ, skidQ, rstVal;
  bufState_e state;
  logic      validQ, readyQ;
  logic      accept, drain;

  decode_imm_gen #(.XLEN(XLEN), .RV64_OPS(RV64_OPS)) uImmGen (
    .iInstr   (iInstr),
    .oImm     (decIn.imm),
    .oFmt     (decIn.fmt),
    .oIllegal (decIn.illegal)
  );

  assign decIn.opcode = iInstr[6:0];
  assign decIn.rd     = iInstr[11:7];
  assign decIn.funct3 = iInstr[14:12];
  assign decIn.rs1    = iInstr[19:15];
  assign decIn.rs2    = iInstr[24:20];
  assign decIn.funct7 = iInstr[31:25];
  assign decIn.pc     = iPc;

  always_comb begin
    rstVal     = '0;
    rstVal.fmt = FMT_NONE;
  end

  assign accept = iValid && readyQ;
  assign drain  = validQ && iReady;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= BUF_EMPTY;
      validQ <= 1'b0;
      readyQ <= 1'b1;
      outQ   <= rstVal;
      skidQ  <= rstVal;
    end else if (iFlush) begin
      state  <= BUF_EMPTY;
      validQ <= 1'b0;
      readyQ <= 1'b1;
    end else begin
      case (state)
        BUF_EMPTY: if (accept) begin
          outQ   <= decIn;
          validQ <= 1'b1;
          state  <= BUF_ONE;
        end
        BUF_ONE: begin
          if (accept && !drain) begin
            skidQ  <= decIn;
            readyQ <= 1'b0;
            state  <= BUF_FULL;
          end else if (accept) begin
            outQ <= decIn;
          end else if (drain) begin
            validQ <= 1'b0;
            state  <= BUF_EMPTY;
          end
        end
        // No accept is possible here: readyQ is low while FULL.
        BUF_FULL: if (drain) begin
          outQ   <= skidQ;
          readyQ <= 1'b1;
          state  <= BUF_ONE;
        end
        default: begin
          state  <= BUF_EMPTY;
          validQ <= 1'b0;
          readyQ <= 1'b1;
        end
      endcase
    end
  end

`ifdef DECODE_STAGE_PERF_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oRetCnt <= '0;
      oIllCnt <= '0;
    end else if (drain && !iFlush) begin
      oRetCnt <= oRetCnt + 32'd1;
      if (outQ.illegal) oIllCnt <= oIllCnt + 16'd1;
    end
  end
`endif

  assign oReady   = readyQ;
  assign oValid   = validQ;
  assign oOpcode  = outQ.opcode;
  assign oRd      = outQ.rd;
  assign oFunct3  = outQ.funct3;
  assign oRs1     = outQ.rs1;
  assign oRs2     = outQ.rs2;
  assign oFunct7  = outQ.funct7;
  assign oImm     = outQ.imm;
  assign oFmt     = outQ.fmt;
  assign oPc      = outQ.pc;
  assign oIllegal = outQ.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage at XLEN=64, RV64_OPS=0: vector table, occupancy model and scoreboard queue.
module tb_decode_stage;

  localparam int XLEN = 64;

  logic            iClk = 1'b0;
  logic            iRst, iFlush, iValid, iReady;
  logic [31:0]     iInstr;
  logic [XLEN-1:0] iPc;
  logic            oReady, oValid, oIllegal;
  logic [6:0]      oOpcode, oFunct7;
  logic [4:0]      oRd, oRs1, oRs2;
  logic [2:0]      oFunct3, oFmt;
  logic [XLEN-1:0] oImm, oPc;
`ifdef DECODE_STAGE_PERF_EN
  logic [31:0]     oRetCnt;
  logic [15:0]     oIllCnt;
`endif

  always #5 iClk = ~iClk;

  decode_stage #(.XLEN(XLEN), .RV64_OPS(1'b0)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iPc(iPc), .oValid(oValid), .iReady(iReady),
    .oOpcode(oOpcode), .oRd(oRd), .oFunct3(oFunct3), .oRs1(oRs1), .oRs2(oRs2),
    .oFunct7(oFunct7), .oImm(oImm), .oFmt(oFmt), .oPc(oPc), .oIllegal(oIllegal)
`ifdef DECODE_STAGE_PERF_EN
    , .oRetCnt(oRetCnt), .oIllCnt(oIllCnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  localparam int NVEC = 16;
  vec_t  vecs[NVEC];
  exp_t  sbQ[$];
  int    errors = 0;
  int    checks = 0;
  int    occ = 0;
  logic  holdChk = 1'b0;
  logic [63:0] holdPc, holdImm;
  logic [31:0] retCnt = '0;
  logic [15:0] illCnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, judge at negedge, advance the model for the coming edge.
  task automatic step(input logic v, input int idx, input logic [63:0] pc,
                      input logic rdy, input logic fl, output logic took);
    logic acc, drn;
    exp_t e;
    iValid = v; iInstr = vecs[idx].instr; iPc = pc; iReady = rdy; iFlush = fl;
    @(negedge iClk);
    chk("oValid", 64'(oValid), 64'(occ != 0));
    chk("oReady", 64'(oReady), 64'(occ < 2));
    if (holdChk) begin
      chk("holdPc", oPc, holdPc);
      chk("holdImm", oImm, holdImm);
    end
    acc = v && (occ < 2);
    drn = (occ != 0) && rdy;
    if (drn && !fl) begin
      if (sbQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: DUT output with nothing expected");
      end else begin
        e = sbQ.pop_front();
        chk("oPc", oPc, e.pc);
        chk("oImm", oImm, e.imm);
        chk("oFmt", 64'(oFmt), 64'(e.fmt));
        chk("oIllegal", 64'(oIllegal), 64'(e.ill));
        chk("oOpcode", 64'(oOpcode), 64'(e.instr[6:0]));
        chk("oRd", 64'(oRd), 64'(e.instr[11:7]));
        chk("oFunct3", 64'(oFunct3), 64'(e.instr[14:12]));
        chk("oRs1", 64'(oRs1), 64'(e.instr[19:15]));
        chk("oRs2", 64'(oRs2), 64'(e.instr[24:20]));
        chk("oFunct7", 64'(oFunct7), 64'(e.instr[31:25]));
        retCnt = retCnt + 32'd1;
        if (e.ill) illCnt = illCnt + 16'd1;
      end
    end
    holdChk = (occ != 0) && !rdy && !fl;
    holdPc  = oPc;
    holdImm = oImm;
    if (fl) begin
      sbQ.delete();
      occ = 0;
    end else begin
      if (acc) sbQ.push_back('{vecs[idx].instr, vecs[idx].imm, vecs[idx].fmt, vecs[idx].ill, pc});
      occ = occ + int'(acc) - int'(drn);
    end
    took = acc && !fl;
    @(posedge iClk);
    #1;
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_oValid"}, 64'(oValid), 64'd0);
    chk({tag, "_oReady"}, 64'(oReady), 64'd1);
    chk({tag, "_oFmt"}, 64'(oFmt), 64'd7);
    chk({tag, "_oImm"}, oImm, 64'd0);
    chk({tag, "_oPc"}, oPc, 64'd0);
    chk({tag, "_oIllegal"}, 64'(oIllegal), 64'd0);
    chk({tag, "_oRd"}, 64'(oRd), 64'd0);
`ifdef DECODE_STAGE_PERF_EN
    chk({tag, "_oRetCnt"}, 64'(oRetCnt), 64'd0);
    chk({tag, "_oIllCnt"}, 64'(oIllCnt), 64'd0);
`endif
  endtask

  initial begin
    logic        took;
    logic [63:0] pc;

    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}; // addi x1,x0,-1
    vecs[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0}; // beq -4
    vecs[2]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui x1,0x80000
    vecs[3]  = '{32'h00000000, 64'h0,                   3'd7, 1'b1};
    vecs[4]  = '{32'h0000003B, 64'h0,                   3'd7, 1'b1}; // OP-32 without RV64_OPS
    vecs[5]  = '{32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0}; // sw x2,-8(x1)
    vecs[6]  = '{32'h801000EF, 64'hFFFF_FFFF_FFF0_0800, 3'd5, 1'b0}; // jal, imm[20]|imm[11]
    vecs[7]  = '{32'h000FF0EF, 64'h0000_0000_000F_F000, 3'd5, 1'b0}; // jal, imm[19:12]
    vecs[8]  = '{32'h12345297, 64'h0000_0000_1234_5000, 3'd4, 1'b0}; // auipc x5
    vecs[9]  = '{32'h002081B3, 64'h0,                   3'd0, 1'b0}; // add x3,x1,x2
    vecs[10] = '{32'h80008067, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0}; // jalr -2048
    vecs[11] = '{32'h0FF0000F, 64'h0000_0000_0000_00FF, 3'd1, 1'b0}; // fence
    vecs[12] = '{32'h0000001B, 64'h0,                   3'd7, 1'b1}; // OP-IMM-32 without RV64_OPS
    vecs[13] = '{32'hFFF00090, 64'h0,                   3'd7, 1'b1}; // low bits 00
    vecs[14] = '{32'h00000073, 64'h0,                   3'd1, 1'b0}; // ecall
    vecs[15] = '{32'h7FF0A183, 64'h0000_0000_0000_07FF, 3'd1, 1'b0}; // lw x3,2047(x1)

    iRst = 1'b1; iFlush = 1'b0; iValid = 1'b0; iReady = 1'b0; iInstr = '0; iPc = '0;
    repeat (2) @(posedge iClk);
    #1;
    chkResetVals("reset");
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    // Back-to-back stream through every vector with no backpressure.
    pc = 64'h1000;
    for (int i = 0; i < NVEC; i++) begin
      step(1'b1, i, pc, 1'b1, 1'b0, took);
      if (took) pc = pc + 64'd4;
    end
    repeat (2) step(1'b0, 0, pc, 1'b1, 1'b0, took);

    // Fill to FULL under backpressure, third request held, then drain in order.
    step(1'b1, 0, 64'h0, 1'b0, 1'b0, took);
    step(1'b1, 1, 64'h4, 1'b0, 1'b0, took);
    step(1'b1, 2, 64'h8, 1'b0, 1'b0, took);
    step(1'b1, 2, 64'h8, 1'b1, 1'b0, took);
    step(1'b1, 2, 64'h8, 1'b1, 1'b0, took);
    chk("thirdAccepted", 64'(took), 64'd1);
    step(1'b0, 0, 64'h0, 1'b1, 1'b0, took);
    step(1'b0, 0, 64'h0, 1'b1, 1'b0, took);

    // Flush while FULL with a new request presented: it must be dropped.
    step(1'b1, 3, 64'h100, 1'b0, 1'b0, took);
    step(1'b1, 4, 64'h104, 1'b0, 1'b0, took);
    step(1'b1, 5, 64'h108, 1'b0, 1'b1, took);
    step(1'b0, 0, 64'h0, 1'b1, 1'b0, took);
    step(1'b0, 0, 64'h0, 1'b1, 1'b0, took);

    // Random traffic with random backpressure and occasional flushes.
    pc = 64'h2000;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, NVEC - 1)), pc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, took);
      if (took) pc = pc + 64'd4;
    end
    repeat (3) step(1'b0, 0, pc, 1'b1, 1'b0, took);
    chk("drainedAll", 64'(sbQ.size()), 64'd0);
`ifdef DECODE_STAGE_PERF_EN
    @(negedge iClk);
    chk("oRetCnt", 64'(oRetCnt), 64'(retCnt));
    chk("oIllCnt", 64'(oIllCnt), 64'(illCnt));
    @(posedge iClk);
    #1;
`endif

    // Asynchronous reset while FULL: outputs clear before the next clock edge.
    step(1'b1, 6, 64'h300, 1'b0, 1'b0, took);
    step(1'b1, 7, 64'h304, 1'b0, 1'b0, took);
    #2;
    iRst = 1'b1;
    #1;
    chkResetVals("asyncRst");
    sbQ.delete();
    occ = 0;
    holdChk = 1'b0;
    retCnt = '0;
    illCnt = '0;
    iValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    // Recovery after reset.
    step(1'b1, 8, 64'h400, 1'b1, 1'b0, took);
    step(1'b1, 9, 64'h404, 1'b1, 1'b0, took);
    repeat (2) step(1'b0, 0, 64'h0, 1'b1, 1'b0, took);
`ifdef DECODE_STAGE_PERF_EN
    @(negedge iClk);
    chk("oRetCntAfterRst", 64'(oRetCnt), 64'(retCnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
